// File: rtl/rca_operand_sequencer.sv
// Narrow-bus sequencer for the external ripple-carry adder: loads A/B chunk-wise,
// waits for the carry chain to settle, then streams the captured sum back out.
//
// state      | meaning
// S_LOAD_A   | accepting operand A beats, LS chunk first
// S_LOAD_B   | accepting operand B beats; carry-in taken with the last one
// S_SETTLE   | adder inputs held while the ripple chain settles
// S_SEND     | streaming captured sum beats, carry-out held alongside
module rca_operand_sequencer #(
   parameter int WIDTH  = 100,
   parameter int CHUNK  = 25,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CHUNK-1:0] in_data,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CHUNK-1:0] out_data,
   output logic             out_last,
   output logic             out_cout,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [IW-1:0] IDX_LAST   = IW'(NCHUNK - 1);
   localparam logic [CW-1:0] SETTLE_TC0 = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_LOAD_A = 2'd0,
      S_LOAD_B = 2'd1,
      S_SETTLE = 2'd2,
      S_SEND   = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IW-1:0]    idx_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             in_fire;
   logic             out_fire;
   logic             idx_at_last;
   logic             settle_tc;

   assign in_fire     = in_valid & in_ready;
   assign out_fire    = out_valid & out_ready;
   assign idx_at_last = (idx_q == IDX_LAST);
   assign settle_tc   = (cnt_q == '0);
   assign out_cout    = cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_LOAD_A;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD_A: if (in_fire && idx_at_last) state_d = S_LOAD_B;
         S_LOAD_B: if (in_fire && idx_at_last) state_d = S_SETTLE;
         S_SETTLE: if (settle_tc)              state_d = S_SEND;
         S_SEND:   if (out_fire && idx_at_last) state_d = S_LOAD_A;
         default:                              state_d = S_LOAD_A;
      endcase
   end

   // Outside SEND the result mux is parked on chunk 0 regardless of the load index.
   always_comb begin
      in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
      out_valid = (state_q == S_SEND);
      out_last  = (state_q == S_SEND) && idx_at_last;
      out_data  = result_q[CHUNK-1:0];
      if (state_q == S_SEND) begin
         for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) out_data = result_q[k*CHUNK +: CHUNK];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         cnt_q    <= '0;
         add_a    <= '0;
         add_b    <= '0;
         add_cin  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD_A: begin
               if (in_fire) begin
                  for (int k = 0; k < NCHUNK; k++) begin
                     if (idx_q == IW'(k)) add_a[k*CHUNK +: CHUNK] <= in_data;
                  end
                  idx_q <= idx_at_last ? '0 : idx_q + 1'b1;
               end
            end
            S_LOAD_B: begin
               if (in_fire) begin
                  for (int k = 0; k < NCHUNK; k++) begin
                     if (idx_q == IW'(k)) add_b[k*CHUNK +: CHUNK] <= in_data;
                  end
                  if (idx_at_last) begin
                     idx_q   <= '0;
                     add_cin <= in_cin;
                     cnt_q   <= SETTLE_TC0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            // Down-counter loaded with SETTLE-1; capture lands exactly SETTLE edges after the last B beat.
            S_SETTLE: begin
               if (settle_tc) begin
                  result_q <= add_sum;
                  cout_q   <= add_cout;
                  idx_q    <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_SEND: begin
               if (out_fire) idx_q <= idx_at_last ? '0 : idx_q + 1'b1;
            end
            default: idx_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// Scoreboard bench: expected sum beats are queued as operands are issued and
// a negedge monitor checks every accepted result beat against them.
module tb_rca_operand_sequencer;

   localparam int WIDTH  = 100;
   localparam int CHUNK  = 25;
   localparam int SETTLE = 4;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [CHUNK-1:0] in_data;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [CHUNK-1:0] out_data;
   logic             out_last;
   logic             out_cout;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   typedef struct {
      logic [CHUNK-1:0] data;
      logic             last;
      logic             cout;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e;
   int    total = 0;
   int    bad   = 0;
   logic  rand_bp = 1'b0;

   always #5 clk = ~clk;

   // Stand-in for the external ripple-carry adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

   rca_operand_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SETTLE(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_cin   (in_cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .out_cout (out_cout),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   task automatic chk(input string nm, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_beat(input logic [CHUNK-1:0] d, input logic c, input bit gaps);
      int n;
      if (gaps) begin
         n = $urandom_range(0, 3);
         repeat (n) tick();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_cin   = c;
      n = 0;
      while (!in_ready && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("in_ready_timeout", {{WIDTH{1'b0}}, in_ready}, 1);
      tick();
      in_valid = 1'b0;
      in_cin   = 1'b0;
   endtask

   task automatic send_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input bit gaps);
      logic [WIDTH:0] s;
      beat_t e;
      for (int k = 0; k < NCHUNK; k++) put_beat(a[k*CHUNK +: CHUNK], 1'b0, gaps);
      for (int k = 0; k < NCHUNK - 1; k++) put_beat(b[k*CHUNK +: CHUNK], 1'b0, gaps);
      s = model_sum(a, b, cin);
      for (int k = 0; k < NCHUNK; k++) begin
         e.data = s[k*CHUNK +: CHUNK];
         e.last = (k == NCHUNK - 1);
         e.cout = s[WIDTH];
         exp_q.push_back(e);
      end
      put_beat(b[WIDTH-CHUNK +: CHUNK], cin, gaps);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) chk("drain_timeout", WIDTH'(exp_q.size()), 0);
      tick();
      tick();
   endtask

   always begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got data %0h with no result pending", out_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", {{(WIDTH+1-CHUNK){1'b0}}, out_data}, {{(WIDTH+1-CHUNK){1'b0}}, mon_e.data});
            chk("out_last", {{WIDTH{1'b0}}, out_last}, {{WIDTH{1'b0}}, mon_e.last});
            chk("out_cout", {{WIDTH{1'b0}}, out_cout}, {{WIDTH{1'b0}}, mon_e.cout});
            if (mon_e.last) begin
               @(posedge clk);
               #1;
               chk("in_ready_after_last", {{WIDTH{1'b0}}, in_ready}, 1);
               chk("out_valid_after_last", {{WIDTH{1'b0}}, out_valid}, 0);
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {{WIDTH{1'b0}}, in_ready}, 1);
      chk({tag, "_out_valid"}, {{WIDTH{1'b0}}, out_valid}, 0);
      chk({tag, "_out_last"}, {{WIDTH{1'b0}}, out_last}, 0);
      chk({tag, "_out_data"}, {{(WIDTH+1-CHUNK){1'b0}}, out_data}, 0);
      chk({tag, "_out_cout"}, {{WIDTH{1'b0}}, out_cout}, 0);
      chk({tag, "_add_a"}, {1'b0, add_a}, 0);
      chk({tag, "_add_b"}, {1'b0, add_b}, 0);
      chk({tag, "_add_cin"}, {{WIDTH{1'b0}}, add_cin}, 0);
   endtask

   initial begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH:0]   s;
      int               n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      #3;
      chk_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: basic add with latency check
      send_txn(WIDTH'(5), WIDTH'(7), 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("settle_latency", WIDTH'(n), WIDTH'(SETTLE));
      wait_drain();

      // 2: wrap to zero with carry-out
      send_txn(WIDTH'(1), {WIDTH{1'b1}}, 1'b0, 1'b0);
      wait_drain();

      // 3: top chunk placement
      a = '0;
      a[WIDTH-1] = 1'b1;
      send_txn(a, a, 1'b1, 1'b0);
      wait_drain();

      // 4: backpressure on the second result beat
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      s = model_sum(a, b, 1'b1);
      out_ready = 1'b0;
      send_txn(a, b, 1'b1, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("stall_data", {{(WIDTH+1-CHUNK){1'b0}}, out_data}, {{(WIDTH+1-CHUNK){1'b0}}, s[CHUNK +: CHUNK]});
         chk("stall_last", {{WIDTH{1'b0}}, out_last}, 0);
         chk("stall_cout", {{WIDTH{1'b0}}, out_cout}, {{WIDTH{1'b0}}, s[WIDTH]});
         chk("stall_valid", {{WIDTH{1'b0}}, out_valid}, 1);
         chk("stall_in_ready", {{WIDTH{1'b0}}, in_ready}, 0);
         tick();
      end
      out_ready = 1'b1;
      wait_drain();

      // 5: gapped operands, then reset in the middle of the next LOAD_B
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send_txn(a, b, 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
      for (int k = 0; k < NCHUNK; k++) put_beat(CHUNK'($urandom), 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) put_beat(CHUNK'($urandom), 1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk_reset_outputs("postreset");
      send_txn(WIDTH'(3), WIDTH'(4), 1'b0, 1'b0);
      wait_drain();

      // 6: back-to-back transactions
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send_txn(a, b, 1'b1, 1'b0);
      send_txn(~a, b, 1'b0, 1'b0);
      wait_drain();

      // random operands with input gaps and random output backpressure
      rand_bp = 1'b1;
      for (int t = 0; t < 8; t++) begin
         a = {$urandom, $urandom, $urandom, $urandom};
         b = {$urandom, $urandom, $urandom, $urandom};
         send_txn(a, b, 1'($urandom_range(0, 1)), 1'b1);
      end
      rand_bp = 1'b0;
      #2;
      out_ready = 1'b1;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
